// File: rtl/fb_pkg.sv
// Shared definitions for the reset sequencer: state encoding and small helpers.
package fb_pkg;

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_CAL  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_VOUT = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } seq_state_e;

  // Timer must be able to hold the largest of the three load values.
  function automatic int unsigned tmr_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Stage reset levels {ddr, wr, rd, vout} for a given state; releases are cumulative.
  function automatic logic [3:0] stage_rst_n(seq_state_e s);
    logic [3:0] r;
    r = '0;
    case (s)
      S_CAL:         r = 4'b1000;
      S_WR:          r = 4'b1100;
      S_RD:          r = 4'b1110;
      S_VOUT, S_RUN: r = 4'b1111;
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Bundle of the sequencer's status inputs and stage-reset outputs.
interface rst_seq_ctrl_if;
  logic       pll_locked;
  logic       ddr_init_done;
  logic       soft_rst_req;
  logic       ddr_rst_n_o;
  logic       wr_rst_n_o;
  logic       rd_rst_n_o;
  logic       vout_rst_n_o;
  logic       seq_done_o;
  logic       timeout_err_o;
  logic [2:0] state_o;

  modport master (
    output pll_locked, ddr_init_done, soft_rst_req,
    input  ddr_rst_n_o, wr_rst_n_o, rd_rst_n_o, vout_rst_n_o,
    input  seq_done_o, timeout_err_o, state_o
  );

  modport slave (
    input  pll_locked, ddr_init_done, soft_rst_req,
    output ddr_rst_n_o, wr_rst_n_o, rd_rst_n_o, vout_rst_n_o,
    output seq_done_o, timeout_err_o, state_o
  );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter; load wins over enable, zero flag reflects the current count.
module seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: hold for PLL lock, release DDR, wait for calibration,
// then release write, read and video-output domains one after another.
module rst_seq_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned STAGE_DLY   = 8,
  parameter int unsigned CAL_TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       pll_locked,
  input  logic       ddr_init_done,
  input  logic       soft_rst_req,
  output logic       ddr_rst_n_o,
  output logic       wr_rst_n_o,
  output logic       rd_rst_n_o,
  output logic       vout_rst_n_o,
  output logic       seq_done_o,
  output logic       timeout_err_o,
  output logic [2:0] state_o
);

  localparam int unsigned TW = tmr_width(HOLD_CYC, STAGE_DLY, CAL_TIMEOUT);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] STAGE_LD = TW'(STAGE_DLY - 1);
  localparam logic [TW-1:0] CAL_LD   = TW'(CAL_TIMEOUT - 1);

  seq_state_e    state_q, state_d;
  logic [3:0]    rst_n_q;
  logic          done_q;
  logic          err_q, err_d;
  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;

  seq_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Branch order encodes the event priority; the timer is reloaded through the
  // same path on reset so it needs no reset of its own.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    if (!rst_n_i) begin
      state_d  = S_HOLD;
      err_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = HOLD_LD;
    end else if (!pll_locked) begin
      state_d  = S_HOLD;
      tmr_load = 1'b1;
      tmr_val  = HOLD_LD;
    end else if (soft_rst_req) begin
      state_d  = S_HOLD;
      err_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = HOLD_LD;
    end else if (!ddr_init_done &&
                 (state_q inside {S_WR, S_RD, S_VOUT, S_RUN})) begin
      state_d  = S_HOLD;
      tmr_load = 1'b1;
      tmr_val  = HOLD_LD;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (tmr_zero) begin
            state_d  = S_CAL;
            tmr_load = 1'b1;
            tmr_val  = CAL_LD;
          end else begin
            tmr_en = 1'b1;
          end
        end
        S_CAL: begin
          if (ddr_init_done) begin
            state_d  = S_WR;
            tmr_load = 1'b1;
            tmr_val  = STAGE_LD;
          end else if (tmr_zero) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        S_WR, S_RD, S_VOUT: begin
          if (tmr_zero) begin
            state_d  = (state_q == S_WR) ? S_RD : (state_q == S_RD) ? S_VOUT : S_RUN;
            tmr_load = 1'b1;
            tmr_val  = STAGE_LD;
          end else begin
            tmr_en = 1'b1;
          end
        end
        S_RUN, S_ERR: ;
        default: begin
          state_d  = S_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the state edge.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q <= S_HOLD;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_n_q <= stage_rst_n(state_d);
      done_q  <= (state_d == S_RUN);
      err_q   <= err_d;
    end
  end

  assign ddr_rst_n_o   = rst_n_q[3];
  assign wr_rst_n_o    = rst_n_q[2];
  assign rd_rst_n_o    = rst_n_q[1];
  assign vout_rst_n_o  = rst_n_q[0];
  assign seq_done_o    = done_q;
  assign timeout_err_o = err_q;
  assign state_o       = state_q;

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 16, meaning cycles all resets stay asserted after pll_locked is seen high.
REQ-002 SHALL have parameter STAGE_DLY, default 8, meaning cycles between successive stage releases.
REQ-003 SHALL have parameter CAL_TIMEOUT, default 1048576, meaning max cycles to wait for ddr_init_done.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n_i, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port pll_locked, input, 1, PLL lock status (level).
REQ-007 SHALL have port ddr_init_done, input, 1, DDR calibration complete (level).
REQ-008 SHALL have port soft_rst_req, input, 1, single-cycle request to re-run the sequence.
REQ-009 SHALL have ports ddr_rst_n_o, wr_rst_n_o, rd_rst_n_o and vout_rst_n_o, each output, 1, active-low stage resets for DDR controller, frame write channel, frame read channel and video output.
REQ-010 SHALL have port seq_done_o, output, 1, all stages released.
REQ-011 SHALL have port timeout_err_o, output, 1, sticky calibration-timeout flag.
REQ-012 SHALL have port state_o, output, 3, current state encoding for debug.

Function
REQ-013 SHALL implement states S_HOLD, S_CAL, S_WR, S_RD, S_VOUT, S_RUN and S_ERR, with all outputs registered and updated on the same edge as the state register.
REQ-014 SHALL, in S_HOLD, drive all four resets low and load timer with HOLD_CYC-1; decrement only while pll_locked=1, reload while pll_locked=0.
REQ-015 SHALL leave S_HOLD for S_CAL when timer=0 and pll_locked=1, so that ddr_rst_n_o rises after exactly HOLD_CYC consecutive locked cycles.
REQ-016 SHALL, in S_CAL, hold ddr_rst_n_o=1 with the others low, load timer CAL_TIMEOUT-1 on entry, and go to S_WR on the first cycle ddr_init_done=1.
REQ-017 SHALL go from S_CAL to S_ERR when timer=0 and ddr_init_done=0, i.e. after CAL_TIMEOUT cycles without calibration.
REQ-018 SHALL release wr_rst_n_o on entry to S_WR, rd_rst_n_o on entry to S_RD and vout_rst_n_o on entry to S_VOUT; each of S_WR, S_RD and S_VOUT lasts STAGE_DLY cycles.
REQ-019 SHALL raise seq_done_o on entry to S_RUN and keep all resets high there.
REQ-020 SHALL, in S_ERR, drive all resets low, seq_done_o=0 and timeout_err_o=1, and stay there until soft_rst_req or rst_n_i.
REQ-021 SHALL apply transition priority rst_n_i low > pll_locked low > soft_rst_req > ddr_init_done loss > timeout > normal advance.
REQ-022 SHALL go to S_HOLD from any state other than S_HOLD when pll_locked=0, and from any state when soft_rst_req=1; soft_rst_req also clears timeout_err_o.
REQ-023 SHALL go to S_HOLD when ddr_init_done drops in S_WR, S_RD, S_VOUT or S_RUN.
REQ-024 SHALL drop all resets low and seq_done_o to 0 on the same edge that enters S_HOLD (assert together, release staggered).
REQ-025 SHALL restart S_HOLD with a fresh timer load when soft_rst_req arrives while already in S_HOLD.
REQ-026 SHALL size the timer to clog2(max(HOLD_CYC, STAGE_DLY, CAL_TIMEOUT)) bits, with HOLD_CYC, STAGE_DLY and CAL_TIMEOUT all at least 1.

Reset
REQ-027 SHALL, with rst_n_i=0 at a clk edge, set state=S_HOLD, timer=HOLD_CYC-1, all four resets=0, seq_done_o=0 and timeout_err_o=0.
REQ-028 SHALL treat rst_n_i mid-sequence identically to power-on: there is no retained progress except the reset values of REQ-027.

Structure
REQ-029 SHALL place the state encoding constants in the shared package fb_pkg.
REQ-030 SHALL use one sub-module, seq_timer: a loadable down-counter with load, load value, enable and zero flag.

Verification
REQ-031 SHALL cover nominal bring-up: lock at cycle 10, ddr_init_done at cycle 100 -> ddr_rst_n_o rises at 26, wr at 101, rd at 109, vout at 117, seq_done_o at 125.
REQ-032 SHALL cover lock glitch: pll_locked low for 1 cycle after 10 locked cycles in S_HOLD -> timer reloads; ddr_rst_n_o rises 16 cycles after relock.
REQ-033 SHALL cover timeout: CAL_TIMEOUT=1000 with ddr_init_done never set -> S_ERR 1000 cycles after S_CAL entry, timeout_err_o=1; soft_rst_req -> timeout_err_o=0, state S_HOLD.
REQ-034 SHALL cover run-time loss: in S_RUN, pll_locked drop -> all resets and seq_done_o low on the next edge, then full re-sequence.
REQ-035 SHALL cover simultaneous events: soft_rst_req and ddr_init_done rise in the same S_CAL cycle -> S_HOLD wins; rst_n_i low during S_RD -> REQ-027 values on the next edge.
